// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encoding is fixed because board-level debug probes decode it directly.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    WAIT_HIGH   = 2'b01,
    HIGH_STABLE = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  localparam int STABLE_TICKS_DEF = 3;
  localparam int SYNC_STAGES_DEF  = 2;

endpackage

// File: rtl/sync_chain.sv
// Metastability synchronizer: STAGES-deep flop chain, q lags d by STAGES cycles.
// No backpressure; async active-low reset clears every stage to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Button debouncer: level flips after STABLE_TICKS consecutive ticks of a changed input.
// Latency SYNC_STAGES+1 cycles into WAIT, then the confirming tick, then 1 cycle; no backpressure.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int                CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             btn_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // Outputs are assigned on the same edge as the state change, so they never lag it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOW_STABLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        LOW_STABLE: begin
          if (btn_s) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          // A bounce takes priority over a coincident tick.
          if (!btn_s) begin
            state <= LOW_STABLE;
            cnt   <= '0;
          end else if (tick && (cnt == CNT_LAST)) begin
            state     <= HIGH_STABLE;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH_STABLE: begin
          if (!btn_s) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (btn_s) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
          end else if (tick && (cnt == CNT_LAST)) begin
            state       <= LOW_STABLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= LOW_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm: expected strobe edges are predicted from the tick schedule.
// STABLE_TICKS=3, SYNC_STAGES=2, tick sampled on every edge whose index is 9 mod 10.
module tb_debounce_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  logic tick_en = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [1:0] kind;   // 2'b10 press, 2'b01 release
    int         edge_n;
  } ev_t;

  ev_t sb[$];

  debounce_fsm #(
    .STABLE_TICKS (3),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial forever #5 clk = ~clk;

  // cyc counts rising edges; inputs driven at a negedge are sampled at edge index cyc.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) tick = tick_en && ((cyc % 10) == 9);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Index of the k-th tick edge at or after edge 'from'.
  function automatic int nth_tick(input int from, input int k);
    int m = from;
    int c = 0;
    while (1) begin
      if ((m % 10) == 9) begin
        c++;
        if (c == k) return m;
      end
      m++;
    end
  endfunction

  // Input changed at edge n: FSM enters WAIT at n+2, so ticks from n+3 count.
  function automatic int confirm_edge(input int n);
    return nth_tick(n + 3, 3);
  endfunction

  task automatic expect_ev(input logic [1:0] kind, input int edge_n);
    ev_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (btn_press || btn_release) begin
      check("strobe_excl", int'(btn_press & btn_release), 0);
      if (sb.size() == 0) begin
        check("spurious_strobe", int'({btn_press, btn_release}), 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("strobe_kind", int'({btn_press, btn_release}), int'(e.kind));
        check("strobe_edge", cyc - 1, e.edge_n);
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, t2, g;
    @(negedge clk);

    // Reset hold with button pressed and ticks running.
    btn_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("rst_hold_outs", int'({btn_level, btn_press, btn_release}), 0);
    end
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_level", int'(btn_level), 0);

    // Clean press then clean release.
    n = cyc; btn_in = 1'b1;
    c = confirm_edge(n);
    expect_ev(2'b10, c);
    wait_until(c);
    check("press_level_pre", int'(btn_level), 0);
    wait_drain(100);
    check("press_level", int'(btn_level), 1);
    repeat (20) @(negedge clk);
    check("press_level_hold", int'(btn_level), 1);

    n = cyc; btn_in = 1'b0;
    c = confirm_edge(n);
    expect_ev(2'b01, c);
    wait_until(c);
    check("release_level_pre", int'(btn_level), 1);
    wait_drain(100);
    check("release_level", int'(btn_level), 0);

    // Bounce: toggle every 4 cycles for 60 cycles, then settle high.
    for (int i = 0; i < 15; i++) begin
      btn_in = ~btn_in;
      repeat (4) @(negedge clk);
    end
    check("bounce_level", int'(btn_level), 0);
    btn_in = 1'b0;
    repeat (4) @(negedge clk);
    n = cyc; btn_in = 1'b1;
    expect_ev(2'b10, confirm_edge(n));
    wait_drain(100);
    check("bounce_press_level", int'(btn_level), 1);

    n = cyc; btn_in = 1'b0;
    expect_ev(2'b01, confirm_edge(n));
    wait_drain(100);
    check("bounce_release_level", int'(btn_level), 0);

    // Glitch after two counted ticks restarts the count.
    n = cyc; btn_in = 1'b1;
    t2 = nth_tick(n + 3, 2);
    wait_until(t2 + 1);
    g = cyc; btn_in = 1'b0;
    @(negedge clk);
    btn_in = 1'b1;
    expect_ev(2'b10, confirm_edge(g + 1));
    wait_drain(100);
    check("glitch_level", int'(btn_level), 1);

    n = cyc; btn_in = 1'b0;
    expect_ev(2'b01, confirm_edge(n));
    wait_drain(100);
    check("glitch_release_level", int'(btn_level), 0);

    // Revert coincides with the confirming tick: revert wins.
    n = cyc; btn_in = 1'b1;
    c = confirm_edge(n);
    wait_until(c - 2);
    btn_in = 1'b0;
    repeat (30) @(negedge clk);
    check("collision_level", int'(btn_level), 0);
    n = cyc; btn_in = 1'b1;
    expect_ev(2'b10, confirm_edge(n));
    wait_drain(100);
    check("collision_press_level", int'(btn_level), 1);

    // Reset while in WAIT_LOW with cnt=2.
    n = cyc; btn_in = 1'b0;
    t2 = nth_tick(n + 3, 2);
    wait_until(t2 + 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outs", int'({btn_level, btn_press, btn_release}), 0);
    btn_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_outs", int'({btn_level, btn_press, btn_release}), 0);
    n = cyc; rst = 1'b1;
    c = confirm_edge(n);
    expect_ev(2'b10, c);
    wait_until(c);
    check("rst_repress_pre", int'(btn_level), 0);
    wait_drain(100);
    check("rst_repress_level", int'(btn_level), 1);

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
